bp_fe_lce_cmd_rx: RTL and testbench
===================================

Name: bp_fe_lce_cmd_rx

Overview:
Front-end I-cache LCE command receiver. Sits downstream of the CCE command network and directly feeds the LCE request FSM.
- Accepts one CCE command at a time.
- Issues the matching tag-memory or data-memory write to the I-cache.
- Returns sync/invalidate acknowledgements to the CCE.
- Pulses the completion strobes the request FSM waits on: data received, uncached data received, set-tag received, set-tag-wakeup received.
- Reports when it is stalled on cache memory access.

Parameters:
paddr_width_p, 40, physical address width
sets_p, 64, I-cache sets; index_width_lp = clog2(sets_p)
assoc_p, 8, ways; way_width_lp = clog2(assoc_p)
block_width_p, 512, cache block bits
dword_width_p, 64, uncached data width
block_offset_width_lp, clog2(block_width_p/8), derived
tag_width_lp, paddr_width_p-index_width_lp-block_offset_width_lp, derived

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
cmd_type_i  in  3  0 sync, 1 set_clear, 2 invalidate, 3 set_tag, 4 set_tag_wakeup, 5 data, 6 uc_data, 7 reserved
cmd_addr_i  in  paddr_width_p  command address
cmd_way_i  in  way_width_lp  target way
cmd_state_i  in  2  coherence state for set_tag*
cmd_data_i  in  block_width_p  block data; uc_data uses [dword_width_p-1:0]
cmd_v_i  in  1  command valid
cmd_ready_o  out  1  command accept
tag_w_v_o  out  1  tag write request
tag_w_index_o  out  index_width_lp  set index
tag_w_way_o  out  way_width_lp  way
tag_w_tag_o  out  tag_width_lp  tag
tag_w_state_o  out  2  coherence state; 0 = invalid
tag_w_clear_all_o  out  1  set_clear: invalidate all ways of the index
tag_w_yumi_i  in  1  tag write taken
data_w_v_o  out  1  data write request
data_w_index_o  out  index_width_lp  set index
data_w_way_o  out  way_width_lp  way
data_w_data_o  out  block_width_p  block
data_w_yumi_i  in  1  data write taken
resp_v_o  out  1  response valid
resp_type_o  out  2  1 sync_ack, 2 inv_ack
resp_addr_o  out  paddr_width_p  echoed command address
resp_yumi_i  in  1  response taken
uc_data_o  out  dword_width_p  uncached data; held until next uc_data
cce_data_received_o  out  1  one-cycle pulse
uncached_data_received_o  out  1  one-cycle pulse
set_tag_received_o  out  1  one-cycle pulse
set_tag_wakeup_received_o  out  1  one-cycle pulse
coherence_blocked_o  out  1  write pending and not yumi'd this cycle

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - State is READY.
  - Command registers are 0 and uc_data_o is 0.
  - All valid outputs and pulses are 0, and cmd_ready_o is 0 while reset is asserted.
- States: READY, TAG_WR, DATA_WR, RESP.
- READY:
  - cmd_ready_o = 1.
  - On cmd_v_i & cmd_ready_o, capture all cmd fields and dispatch on type:
    - sync -> RESP with type sync_ack.
    - set_clear -> TAG_WR with clear_all=1 and state=0.
    - invalidate -> TAG_WR with state=0, then RESP with type inv_ack.
    - set_tag or set_tag_wakeup -> TAG_WR with state=cmd_state.
    - data -> DATA_WR.
    - uc_data -> load uc_data_o; uncached_data_received_o pulses the next cycle; remain in READY.
    - reserved -> dropped; remain in READY.
  - cmd_ready_o is 0 in every state other than READY.
- Address fields: index = addr[block_offset_width_lp +: index_width_lp]; tag = addr[paddr_width_p-1 -: tag_width_lp].
- TAG_WR:
  - tag_w_v_o = 1; outputs are driven from registers and are stable until tag_w_yumi_i.
  - On yumi: invalidate goes to RESP; all other types go to READY.
  - On yumi, set_tag_received_o or set_tag_wakeup_received_o pulses in the same cycle, matching the command type.
- DATA_WR:
  - data_w_v_o = 1.
  - On data_w_yumi_i: cce_data_received_o pulses in the same cycle and the FSM goes to READY.
- RESP:
  - resp_v_o = 1; resp_addr_o = captured address.
  - On resp_yumi_i, go to READY.
  - resp_v_o must not depend on resp_yumi_i.
- coherence_blocked_o = (tag_w_v_o & ~tag_w_yumi_i) | (data_w_v_o & ~data_w_yumi_i).
- Pulses:
  - At most one pulse is asserted per cycle.
  - Each pulse is exactly one cycle wide, regardless of how long yumi stays high.
- Throughput: minimum one command per 2 cycles; uc_data sustains one per cycle.
- Yumi asserted while the corresponding valid is low is ignored.
- Asynchronous reset mid-operation:
  - Returns to READY immediately.
  - Any pending write or response is abandoned.
  - No pulse is emitted.

Test Plan:
- set_tag, addr 0x8000_1040, way 3, state 2, yumi 2 cycles later -> tag_w_index_o=0x01; tag_w_v_o held 3 cycles; set_tag_received_o pulses once in the yumi cycle; FSM back to READY.
- invalidate, addr 0x40, way 5 -> tag write with state 0; then resp_v_o with type 2 and addr 0x40, held until yumi; cmd_ready_o=0 throughout.
- data cmd with pattern 0xA5.., data_w_yumi_i held low 4 cycles -> coherence_blocked_o=1 for 4 cycles; cce_data_received_o pulses once when yumi rises.
- Back-to-back uc_data 0x1111 then 0x2222 -> both accepted on consecutive cycles; uncached_data_received_o pulses 2 cycles in a row; uc_data_o=0x2222 afterwards.
- sync followed immediately by set_tag_wakeup -> sync_ack sent; second cmd stalled until RESP is yumi'd; then set_tag_wakeup_received_o pulses.
- reset_n_i dropped mid-DATA_WR -> all outputs 0 asynchronously; after release cmd_ready_o=1 and no stale pulse.

Source files
------------

// File: rtl/bp_fe_lce_cmd_rx.sv
// Front-end I-cache LCE command receiver.
// Accepts one CCE command at a time, issues the matching tag or data write
// to the I-cache, returns sync/invalidate acks and pulses the completion
// strobes consumed by the LCE request FSM.
module bp_fe_lce_cmd_rx #(
    parameter  int paddr_width_p         = 40,
    parameter  int sets_p                = 64,
    parameter  int assoc_p               = 8,
    parameter  int block_width_p         = 512,
    parameter  int dword_width_p         = 64,
    localparam int index_width_lp        = $clog2(sets_p),
    localparam int way_width_lp          = $clog2(assoc_p),
    localparam int block_offset_width_lp = $clog2(block_width_p / 8),
    localparam int tag_width_lp          = paddr_width_p - index_width_lp - block_offset_width_lp
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic [2:0]                cmd_type_i,
    input  logic [paddr_width_p-1:0]  cmd_addr_i,
    input  logic [way_width_lp-1:0]   cmd_way_i,
    input  logic [1:0]                cmd_state_i,
    input  logic [block_width_p-1:0]  cmd_data_i,
    input  logic                      cmd_v_i,
    output logic                      cmd_ready_o,

    output logic                      tag_w_v_o,
    output logic [index_width_lp-1:0] tag_w_index_o,
    output logic [way_width_lp-1:0]   tag_w_way_o,
    output logic [tag_width_lp-1:0]   tag_w_tag_o,
    output logic [1:0]                tag_w_state_o,
    output logic                      tag_w_clear_all_o,
    input  logic                      tag_w_yumi_i,

    output logic                      data_w_v_o,
    output logic [index_width_lp-1:0] data_w_index_o,
    output logic [way_width_lp-1:0]   data_w_way_o,
    output logic [block_width_p-1:0]  data_w_data_o,
    input  logic                      data_w_yumi_i,

    output logic                      resp_v_o,
    output logic [1:0]                resp_type_o,
    output logic [paddr_width_p-1:0]  resp_addr_o,
    input  logic                      resp_yumi_i,

    output logic [dword_width_p-1:0]  uc_data_o,
    output logic                      cce_data_received_o,
    output logic                      uncached_data_received_o,
    output logic                      set_tag_received_o,
    output logic                      set_tag_wakeup_received_o,
    output logic                      coherence_blocked_o
);

    localparam logic [2:0] CMD_SYNC      = 3'd0;
    localparam logic [2:0] CMD_SET_CLEAR = 3'd1;
    localparam logic [2:0] CMD_INV       = 3'd2;
    localparam logic [2:0] CMD_SET_TAG   = 3'd3;
    localparam logic [2:0] CMD_SET_TAG_W = 3'd4;
    localparam logic [2:0] CMD_DATA      = 3'd5;
    localparam logic [2:0] CMD_UC_DATA   = 3'd6;

    localparam logic [1:0] RESP_SYNC_ACK = 2'd1;
    localparam logic [1:0] RESP_INV_ACK  = 2'd2;

    typedef enum logic [1:0] {
        ST_READY   = 2'd0,
        ST_TAG_WR  = 2'd1,
        ST_DATA_WR = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic                       ready_q;
    logic [2:0]                 type_q;
    logic [paddr_width_p-1:0]   addr_q;
    logic [way_width_lp-1:0]    way_q;
    logic [1:0]                 coh_q;
    logic [block_width_p-1:0]   data_q;
    logic [dword_width_p-1:0]   uc_data_q;
    logic                       uc_pulse_q;

    logic                       load_s;
    logic                       tag_v_s;
    logic                       data_v_s;
    logic                       resp_v_s;
    logic                       tag_done_s;
    logic                       data_done_s;
    logic                       is_set_tag_s;

    // ready_q is low during reset and the first cycle after it, so no command
    // can be taken while the block is coming out of reset.
    assign load_s       = cmd_v_i & ready_q;
    assign tag_v_s      = (state_q == ST_TAG_WR);
    assign data_v_s     = (state_q == ST_DATA_WR);
    assign resp_v_s     = (state_q == ST_RESP);
    assign tag_done_s   = tag_v_s & tag_w_yumi_i;
    assign data_done_s  = data_v_s & data_w_yumi_i;
    assign is_set_tag_s = (type_q == CMD_SET_TAG) | (type_q == CMD_SET_TAG_W);

    // Next-state selection: dispatch a new command or retire the pending one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_READY: begin
                if (load_s) begin
                    case (cmd_type_i)
                        CMD_SYNC:      state_d = ST_RESP;
                        CMD_SET_CLEAR: state_d = ST_TAG_WR;
                        CMD_INV:       state_d = ST_TAG_WR;
                        CMD_SET_TAG:   state_d = ST_TAG_WR;
                        CMD_SET_TAG_W: state_d = ST_TAG_WR;
                        CMD_DATA:      state_d = ST_DATA_WR;
                        default:       state_d = ST_READY;
                    endcase
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_TAG_WR: begin
                if (tag_w_yumi_i) begin
                    state_d = (type_q == CMD_INV) ? ST_RESP : ST_READY;
                end else begin
                    state_d = ST_TAG_WR;
                end
            end
            ST_DATA_WR: begin
                if (data_w_yumi_i) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_DATA_WR;
                end
            end
            ST_RESP: begin
                if (resp_yumi_i) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    // FSM state, command capture and the registered uncached-data strobe.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_READY;
            ready_q    <= 1'b0;
            type_q     <= 3'd0;
            addr_q     <= '0;
            way_q      <= '0;
            coh_q      <= 2'd0;
            data_q     <= '0;
            uc_data_q  <= '0;
            uc_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= (state_d == ST_READY);
            uc_pulse_q <= load_s & (cmd_type_i == CMD_UC_DATA);
            if (load_s) begin
                type_q <= cmd_type_i;
                addr_q <= cmd_addr_i;
                way_q  <= cmd_way_i;
                coh_q  <= cmd_state_i;
                data_q <= cmd_data_i;
            end
            if (load_s && (cmd_type_i == CMD_UC_DATA)) begin
                uc_data_q <= cmd_data_i[dword_width_p-1:0];
            end
        end
    end

    assign cmd_ready_o       = ready_q;

    assign tag_w_v_o         = tag_v_s;
    assign tag_w_index_o     = addr_q[block_offset_width_lp +: index_width_lp];
    assign tag_w_way_o       = way_q;
    assign tag_w_tag_o       = addr_q[paddr_width_p-1 -: tag_width_lp];
    assign tag_w_state_o     = is_set_tag_s ? coh_q : 2'd0;
    assign tag_w_clear_all_o = (type_q == CMD_SET_CLEAR);

    assign data_w_v_o        = data_v_s;
    assign data_w_index_o    = addr_q[block_offset_width_lp +: index_width_lp];
    assign data_w_way_o      = way_q;
    assign data_w_data_o     = data_q;

    assign resp_v_o          = resp_v_s;
    assign resp_type_o       = resp_v_s ? ((type_q == CMD_INV) ? RESP_INV_ACK : RESP_SYNC_ACK) : 2'd0;
    assign resp_addr_o       = addr_q;

    assign uc_data_o         = uc_data_q;

    // Only one state is live at a time, so at most one strobe can fire, and
    // leaving the write state on yumi keeps each strobe a single cycle wide.
    assign cce_data_received_o       = data_done_s;
    assign uncached_data_received_o  = uc_pulse_q;
    assign set_tag_received_o        = tag_done_s & (type_q == CMD_SET_TAG);
    assign set_tag_wakeup_received_o = tag_done_s & (type_q == CMD_SET_TAG_W);

    assign coherence_blocked_o = (tag_v_s & ~tag_w_yumi_i) | (data_v_s & ~data_w_yumi_i);

endmodule

// File: tb/tb_bp_fe_lce_cmd_rx.sv
// Self-checking bench for bp_fe_lce_cmd_rx: directed scenarios followed by
// randomized commands checked against a per-command behavioural model.
module tb_bp_fe_lce_cmd_rx;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [2:0]   cmd_type_i;
    logic [39:0]  cmd_addr_i;
    logic [2:0]   cmd_way_i;
    logic [1:0]   cmd_state_i;
    logic [511:0] cmd_data_i;
    logic         cmd_v_i;
    logic         cmd_ready_o;
    logic         tag_w_v_o;
    logic [5:0]   tag_w_index_o;
    logic [2:0]   tag_w_way_o;
    logic [27:0]  tag_w_tag_o;
    logic [1:0]   tag_w_state_o;
    logic         tag_w_clear_all_o;
    logic         tag_w_yumi_i;
    logic         data_w_v_o;
    logic [5:0]   data_w_index_o;
    logic [2:0]   data_w_way_o;
    logic [511:0] data_w_data_o;
    logic         data_w_yumi_i;
    logic         resp_v_o;
    logic [1:0]   resp_type_o;
    logic [39:0]  resp_addr_o;
    logic         resp_yumi_i;
    logic [63:0]  uc_data_o;
    logic         cce_data_received_o;
    logic         uncached_data_received_o;
    logic         set_tag_received_o;
    logic         set_tag_wakeup_received_o;
    logic         coherence_blocked_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_uc_data = 64'd0;

    bp_fe_lce_cmd_rx dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cmd_type_i(cmd_type_i), .cmd_addr_i(cmd_addr_i), .cmd_way_i(cmd_way_i),
        .cmd_state_i(cmd_state_i), .cmd_data_i(cmd_data_i), .cmd_v_i(cmd_v_i),
        .cmd_ready_o(cmd_ready_o),
        .tag_w_v_o(tag_w_v_o), .tag_w_index_o(tag_w_index_o), .tag_w_way_o(tag_w_way_o),
        .tag_w_tag_o(tag_w_tag_o), .tag_w_state_o(tag_w_state_o),
        .tag_w_clear_all_o(tag_w_clear_all_o), .tag_w_yumi_i(tag_w_yumi_i),
        .data_w_v_o(data_w_v_o), .data_w_index_o(data_w_index_o), .data_w_way_o(data_w_way_o),
        .data_w_data_o(data_w_data_o), .data_w_yumi_i(data_w_yumi_i),
        .resp_v_o(resp_v_o), .resp_type_o(resp_type_o), .resp_addr_o(resp_addr_o),
        .resp_yumi_i(resp_yumi_i),
        .uc_data_o(uc_data_o),
        .cce_data_received_o(cce_data_received_o),
        .uncached_data_received_o(uncached_data_received_o),
        .set_tag_received_o(set_tag_received_o),
        .set_tag_wakeup_received_o(set_tag_wakeup_received_o),
        .coherence_blocked_o(coherence_blocked_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_pulses(input string tag, input logic c, input logic u, input logic s, input logic w);
        chk({tag, "_cce"},  cce_data_received_o,       c);
        chk({tag, "_uc"},   uncached_data_received_o,  u);
        chk({tag, "_st"},   set_tag_received_o,        s);
        chk({tag, "_stw"},  set_tag_wakeup_received_o, w);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, cmd_ready_o, 1'b1);
        chk({tag, "_tagv"},  tag_w_v_o,   1'b0);
        chk({tag, "_datav"}, data_w_v_o,  1'b0);
        chk({tag, "_respv"}, resp_v_o,    1'b0);
        chk({tag, "_ucd"},   uc_data_o,   exp_uc_data);
        chk_pulses(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One command end to end; expectations derived from the command rules.
    task automatic send_cmd(input logic [2:0] t, input logic [39:0] a, input logic [2:0] w,
                            input logic [1:0] s, input logic [511:0] d, input int dly);
        logic       e_tag, e_data, e_resp, e_uc;
        logic [5:0] e_idx;
        logic [27:0] e_tg;
        logic [1:0] e_st;
        e_tag  = (t >= 3'd1) && (t <= 3'd4);
        e_data = (t == 3'd5);
        e_resp = (t == 3'd0) || (t == 3'd2);
        e_uc   = (t == 3'd6);
        e_idx  = 6'((a >> 6) % 64);
        e_tg   = 28'(a >> 12);
        e_st   = (t == 3'd3 || t == 3'd4) ? s : 2'd0;

        @(negedge clk_i);
        cmd_type_i = t; cmd_addr_i = a; cmd_way_i = w; cmd_state_i = s; cmd_data_i = d;
        cmd_v_i = 1'b1;
        tag_w_yumi_i = 1'($urandom); data_w_yumi_i = 1'($urandom); resp_yumi_i = 1'($urandom);
        #1;
        chk("issue_ready", cmd_ready_o, 1'b1);
        chk("issue_blocked", coherence_blocked_o, 1'b0);

        if (e_tag) begin
            for (int k = 0; k <= dly; k++) begin
                @(negedge clk_i);
                cmd_v_i = 1'b0;
                tag_w_yumi_i = (k == dly);
                data_w_yumi_i = 1'($urandom); resp_yumi_i = 1'($urandom);
                #1;
                chk("tag_v", tag_w_v_o, 1'b1);
                chk("tag_ready", cmd_ready_o, 1'b0);
                chk("tag_idx", tag_w_index_o, e_idx);
                chk("tag_way", tag_w_way_o, w);
                chk("tag_tag", tag_w_tag_o, e_tg);
                chk("tag_state", tag_w_state_o, e_st);
                chk("tag_clr", tag_w_clear_all_o, t == 3'd1);
                chk("tag_datav", data_w_v_o, 1'b0);
                chk("tag_respv", resp_v_o, 1'b0);
                chk("tag_blocked", coherence_blocked_o, k != dly);
                chk_pulses("tag", 1'b0, 1'b0, (k == dly) && (t == 3'd3), (k == dly) && (t == 3'd4));
            end
        end
        if (e_data) begin
            for (int k = 0; k <= dly; k++) begin
                @(negedge clk_i);
                cmd_v_i = 1'b0;
                data_w_yumi_i = (k == dly);
                tag_w_yumi_i = 1'($urandom); resp_yumi_i = 1'($urandom);
                #1;
                chk("data_v", data_w_v_o, 1'b1);
                chk("data_ready", cmd_ready_o, 1'b0);
                chk("data_idx", data_w_index_o, e_idx);
                chk("data_way", data_w_way_o, w);
                chk("data_blk", data_w_data_o, d);
                chk("data_tagv", tag_w_v_o, 1'b0);
                chk("data_blocked", coherence_blocked_o, k != dly);
                chk_pulses("data", k == dly, 1'b0, 1'b0, 1'b0);
            end
        end
        if (e_resp) begin
            for (int k = 0; k <= dly; k++) begin
                @(negedge clk_i);
                cmd_v_i = 1'b0;
                resp_yumi_i = (k == dly);
                tag_w_yumi_i = 1'($urandom); data_w_yumi_i = 1'($urandom);
                #1;
                chk("resp_v", resp_v_o, 1'b1);
                chk("resp_ready", cmd_ready_o, 1'b0);
                chk("resp_type", resp_type_o, (t == 3'd2) ? 2'd2 : 2'd1);
                chk("resp_addr", resp_addr_o, a);
                chk("resp_tagv", tag_w_v_o, 1'b0);
                chk("resp_blocked", coherence_blocked_o, 1'b0);
                chk_pulses("resp", 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        if (e_uc) begin
            exp_uc_data = d[63:0];
            @(negedge clk_i);
            cmd_v_i = 1'b0; tag_w_yumi_i = 1'b0; data_w_yumi_i = 1'b0; resp_yumi_i = 1'b0;
            #1;
            chk("uc_ready", cmd_ready_o, 1'b1);
            chk("uc_data", uc_data_o, exp_uc_data);
            chk_pulses("uc", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk_i);
        cmd_v_i = 1'b0; tag_w_yumi_i = 1'b0; data_w_yumi_i = 1'b0; resp_yumi_i = 1'b0;
        #1;
        chk_idle("done");
    endtask

    initial begin
        reset_n_i = 1'b0;
        cmd_type_i = 3'd0; cmd_addr_i = 40'd0; cmd_way_i = 3'd0; cmd_state_i = 2'd0;
        cmd_data_i = 512'd0; cmd_v_i = 1'b0;
        tag_w_yumi_i = 1'b0; data_w_yumi_i = 1'b0; resp_yumi_i = 1'b0;
        #1;
        chk("rst_ready", cmd_ready_o, 1'b0);
        chk("rst_tagv", tag_w_v_o, 1'b0);
        chk("rst_datav", data_w_v_o, 1'b0);
        chk("rst_respv", resp_v_o, 1'b0);
        chk("rst_ucd", uc_data_o, 64'd0);
        chk_pulses("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk_idle("post_rst");

        // set_tag, yumi two cycles after the request appears
        send_cmd(3'd3, 40'h00_8000_1040, 3'd3, 2'd2, rand_block(), 2);
        // invalidate
        send_cmd(3'd2, 40'h00_0000_0040, 3'd5, 2'd3, rand_block(), 2);
        // data with a long stall
        send_cmd(3'd5, 40'h12_3456_7880, 3'd1, 2'd0, {64{8'hA5}}, 4);

        // back-to-back uncached data
        @(negedge clk_i);
        cmd_type_i = 3'd6; cmd_data_i = 512'h1111; cmd_v_i = 1'b1;
        #1; chk("uc2_ready0", cmd_ready_o, 1'b1);
        @(negedge clk_i);
        cmd_data_i = 512'h2222;
        #1;
        chk("uc2_ready1", cmd_ready_o, 1'b1);
        chk("uc2_data1", uc_data_o, 64'h1111);
        chk("uc2_pulse1", uncached_data_received_o, 1'b1);
        @(negedge clk_i);
        cmd_v_i = 1'b0;
        #1;
        chk("uc2_data2", uc_data_o, 64'h2222);
        chk("uc2_pulse2", uncached_data_received_o, 1'b1);
        exp_uc_data = 64'h2222;
        @(negedge clk_i);
        #1; chk_idle("uc2_end");

        // sync followed by a set_tag_wakeup that must wait for the ack
        @(negedge clk_i);
        cmd_type_i = 3'd0; cmd_addr_i = 40'h00_0000_2000; cmd_v_i = 1'b1;
        #1; chk("ss_ready0", cmd_ready_o, 1'b1);
        @(negedge clk_i);
        cmd_type_i = 3'd4; cmd_addr_i = 40'h00_0000_31C0; cmd_way_i = 3'd2; cmd_state_i = 2'd1;
        #1;
        chk("ss_respv", resp_v_o, 1'b1);
        chk("ss_resptype", resp_type_o, 2'd1);
        chk("ss_respaddr", resp_addr_o, 40'h00_0000_2000);
        chk("ss_stall", cmd_ready_o, 1'b0);
        @(negedge clk_i);
        resp_yumi_i = 1'b1;
        #1;
        chk("ss_respv2", resp_v_o, 1'b1);
        chk("ss_tagv0", tag_w_v_o, 1'b0);
        @(negedge clk_i);
        resp_yumi_i = 1'b0;
        #1;
        chk("ss_ready1", cmd_ready_o, 1'b1);
        chk("ss_respv3", resp_v_o, 1'b0);
        @(negedge clk_i);
        cmd_v_i = 1'b0; tag_w_yumi_i = 1'b1;
        #1;
        chk("ss_tagv", tag_w_v_o, 1'b1);
        chk("ss_tagidx", tag_w_index_o, 6'h07);
        chk("ss_tagstate", tag_w_state_o, 2'd1);
        chk_pulses("ss", 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk_i);
        tag_w_yumi_i = 1'b0;
        #1; chk_idle("ss_end");

        // asynchronous reset while a data write is pending
        @(negedge clk_i);
        cmd_type_i = 3'd5; cmd_addr_i = 40'h00_0000_0FC0; cmd_data_i = rand_block(); cmd_v_i = 1'b1;
        #1; chk("ar_ready", cmd_ready_o, 1'b1);
        @(negedge clk_i);
        cmd_v_i = 1'b0;
        #1; chk("ar_datav", data_w_v_o, 1'b1);
        #2 reset_n_i = 1'b0;
        #1;
        chk("ar_datav0", data_w_v_o, 1'b0);
        chk("ar_ready0", cmd_ready_o, 1'b0);
        chk("ar_blocked", coherence_blocked_o, 1'b0);
        chk("ar_ucd", uc_data_o, 64'd0);
        chk("ar_idx", data_w_index_o, 6'd0);
        chk_pulses("ar", 1'b0, 1'b0, 1'b0, 1'b0);
        exp_uc_data = 64'd0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        data_w_yumi_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk("ar_cce", cce_data_received_o, 1'b0);
        data_w_yumi_i = 1'b0;
        chk_idle("ar_end");

        // randomized commands
        for (int n = 0; n < 200; n++) begin
            logic [39:0] a;
            a = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
            send_cmd(3'($urandom_range(0, 7)), a, 3'($urandom), 2'($urandom),
                     rand_block(), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
